// File: rtl/vaccine_wave_controller_if.sv
// Bundle between the vaccine wave controller (slave) and its frame/clamp/random
// sources and drawing logic (master).
interface vaccine_wave_controller_if;
   logic             startOfFrame;
   logic             collision;
   logic [3:0]       collision_index;
   logic             clampIdle;
   logic [10:0]      randX;
   logic [10:0]      randY;
   logic [0:9][10:0] topLeftX;
   logic [0:9][10:0] topLeftY;
   logic [0:9]       draw_request;
   logic             hit_pulse;
   logic             wave_done;
   logic [3:0]       wave_number;

   modport master (
      output startOfFrame, collision, collision_index, clampIdle, randX, randY,
      input  topLeftX, topLeftY, draw_request, hit_pulse, wave_done, wave_number
   );

   modport slave (
      input  startOfFrame, collision, collision_index, clampIdle, randX, randY,
      output topLeftX, topLeftY, draw_request, hit_pulse, wave_done, wave_number
   );
endinterface

// File: rtl/vaccine_wave_controller.sv
// Tracks which of ten vaccines are still on screen, retires them on clamp hits and,
// once a wave is cleared and the clamp is idle, respawns a larger wave at random spots.
module vaccine_wave_controller #(
   parameter int unsigned RESPAWN_FRAMES = 30,
   parameter int unsigned X_MIN          = 16,
   parameter int unsigned X_MAX          = 575,
   parameter int unsigned Y_MIN          = 140,
   parameter int unsigned Y_MAX          = 415
) (
   input  logic                      clk,
   input  logic                      resetN,
   vaccine_wave_controller_if.slave  bus
);

   localparam int unsigned FrameW = (RESPAWN_FRAMES < 2) ? 1 : $clog2(RESPAWN_FRAMES + 1);
   localparam logic [FrameW-1:0] FrameLast = FrameW'(RESPAWN_FRAMES - 1);
   localparam logic [10:0] XMin = 11'(X_MIN);
   localparam logic [10:0] XMax = 11'(X_MAX);
   localparam logic [10:0] YMin = 11'(Y_MIN);
   localparam logic [10:0] YMax = 11'(Y_MAX);

   localparam logic [0:9][10:0] RstX = {11'd70, 11'd80, 11'd140, 11'd200, 11'd170,
                                        11'd330, 11'd370, 11'd480, 11'd440, 11'd550};
   localparam logic [0:9][10:0] RstY = {11'd200, 11'd320, 11'd160, 11'd200, 11'd410,
                                        11'd330, 11'd170, 11'd380, 11'd180, 11'd180};

   typedef enum logic [1:0] {StActive, StWaitClamp, StDelay, StLoad} state_e;

   state_e           state_q, state_d;
   logic [FrameW-1:0] frame_q, frame_d;
   logic [3:0]       load_idx_q, load_idx_d;
   logic [3:0]       wave_q, wave_d;
   logic             hit_q, hit_d;
   logic             done_q, done_d;
   logic [0:9]       draw_q, draw_d;
   logic [0:9][10:0] tlx_q, tlx_d;
   logic [0:9][10:0] tly_q, tly_d;

   logic [0:9]       hit_mask;
   logic             hit_ok;
   logic [3:0]       vis_cnt;
   logic [10:0]      rx_clamped;
   logic [10:0]      ry_clamped;

   always_comb begin
      rx_clamped = (bus.randX < XMin) ? XMin : (bus.randX > XMax) ? XMax : bus.randX;
      ry_clamped = (bus.randY < YMin) ? YMin : (bus.randY > YMax) ? YMax : bus.randY;
      // Wave n shows 4+n vaccines, capped at all ten slots.
      vis_cnt    = (wave_q >= 4'd6) ? 4'd10 : wave_q + 4'd4;

      // Indices 10..15 match no slot, so they can never be accepted.
      hit_mask = '0;
      for (int k = 0; k < 10; k++) begin
         if (bus.collision_index == 4'(k)) hit_mask[k] = 1'b1;
      end
      hit_ok = bus.collision && (|(hit_mask & draw_q));

      state_d    = state_q;
      frame_d    = frame_q;
      load_idx_d = load_idx_q;
      wave_d     = wave_q;
      hit_d      = 1'b0;
      done_d     = 1'b0;
      draw_d     = draw_q;
      tlx_d      = tlx_q;
      tly_d      = tly_q;

      unique case (state_q)
         StActive: begin
            if (hit_ok) begin
               draw_d = draw_q & ~hit_mask;
               hit_d  = 1'b1;
               if (draw_d == '0) begin
                  done_d  = 1'b1;
                  state_d = StWaitClamp;
               end
            end
         end
         StWaitClamp: begin
            if (bus.clampIdle) begin
               frame_d = '0;
               state_d = StDelay;
            end
         end
         StDelay: begin
            if (bus.startOfFrame) begin
               frame_d = frame_q + FrameW'(1);
               if (frame_q == FrameLast) begin
                  wave_d     = wave_q + 4'd1;
                  load_idx_d = '0;
                  draw_d     = '0;
                  state_d    = StLoad;
               end
            end
         end
         StLoad: begin
            for (int k = 0; k < 10; k++) begin
               if (load_idx_q == 4'(k)) begin
                  tlx_d[k]  = rx_clamped;
                  tly_d[k]  = ry_clamped;
                  draw_d[k] = (4'(k) < vis_cnt);
               end
            end
            if (load_idx_q == 4'd9) begin
               load_idx_d = '0;
               state_d    = StActive;
            end else begin
               load_idx_d = load_idx_q + 4'd1;
            end
         end
         default: state_d = StActive;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q    <= StActive;
         frame_q    <= '0;
         load_idx_q <= '0;
         wave_q     <= '0;
         hit_q      <= 1'b0;
         done_q     <= 1'b0;
         draw_q     <= '1;
         tlx_q      <= RstX;
         tly_q      <= RstY;
      end else begin
         state_q    <= state_d;
         frame_q    <= frame_d;
         load_idx_q <= load_idx_d;
         wave_q     <= wave_d;
         hit_q      <= hit_d;
         done_q     <= done_d;
         draw_q     <= draw_d;
         tlx_q      <= tlx_d;
         tly_q      <= tly_d;
      end
   end

   assign bus.topLeftX     = tlx_q;
   assign bus.topLeftY     = tly_q;
   assign bus.draw_request = draw_q;
   assign bus.hit_pulse    = hit_q;
   assign bus.wave_done    = done_q;
   assign bus.wave_number  = wave_q;

endmodule

// File: tb/tb_vaccine_wave_controller.sv
// Directed-plus-random bench for vaccine_wave_controller against a slot-list model
// built from the wave rules (visible set, wave count, clamped spawn positions).
module tb_vaccine_wave_controller;

   logic clk = 1'b0;
   logic resetN;
   always #5 clk = ~clk;

   vaccine_wave_controller_if bus ();

   vaccine_wave_controller dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus)
   );

   int total = 0;
   int bad   = 0;

   int rst_x [10] = '{70, 80, 140, 200, 170, 330, 370, 480, 440, 550};
   int rst_y [10] = '{200, 320, 160, 200, 410, 330, 170, 380, 180, 180};

   int m_x [10];
   int m_y [10];
   bit m_vis [10];
   int m_wave;
   bit m_active;

   task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [0:9] vis_vec();
      logic [0:9] r;
      for (int k = 0; k < 10; k++) r[k] = m_vis[k];
      return r;
   endfunction

   function automatic logic [0:9][10:0] pack_pos(bit is_y);
      logic [0:9][10:0] r;
      for (int k = 0; k < 10; k++) r[k] = 11'(is_y ? m_y[k] : m_x[k]);
      return r;
   endfunction

   function automatic int clampi(int v, int lo, int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   function automatic bit any_vis();
      for (int k = 0; k < 10; k++) if (m_vis[k]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 10; k++) begin
         m_x[k]   = rst_x[k];
         m_y[k]   = rst_y[k];
         m_vis[k] = 1'b1;
      end
      m_wave   = 0;
      m_active = 1'b1;
   endtask

   task automatic check_all(string tag);
      check({tag, ".draw"}, 128'(bus.draw_request), 128'(vis_vec()));
      check({tag, ".x"}, 128'(bus.topLeftX), 128'(pack_pos(1'b0)));
      check({tag, ".y"}, 128'(bus.topLeftY), 128'(pack_pos(1'b1)));
      check({tag, ".wave"}, 128'(bus.wave_number), 128'(m_wave));
   endtask

   // One-clock collision strobe followed by an idle clock.
   task automatic do_hit(int idx);
      bit acc;
      bit last;
      bus.collision       = 1'b1;
      bus.collision_index = 4'(idx);
      step();
      acc  = m_active && (idx <= 9) && m_vis[idx];
      if (acc) m_vis[idx] = 1'b0;
      last = acc && !any_vis();
      if (last) m_active = 1'b0;
      check("hit_pulse", 128'(bus.hit_pulse), 128'(acc));
      check("wave_done", 128'(bus.wave_done), 128'(last));
      check("hit_draw", 128'(bus.draw_request), 128'(vis_vec()));
      bus.collision = 1'b0;
      step();
      check("hit_pulse_drop", 128'(bus.hit_pulse), 128'(0));
      check("wave_done_drop", 128'(bus.wave_done), 128'(0));
   endtask

   task automatic clear_wave();
      int order [10];
      int j;
      int t;
      for (int k = 0; k < 10; k++) order[k] = k;
      for (int k = 9; k > 0; k--) begin
         j = $urandom_range(k, 0);
         t = order[k]; order[k] = order[j]; order[j] = t;
      end
      for (int k = 0; k < 10; k++) begin
         if ($urandom_range(2, 0) == 0) do_hit(10 + $urandom_range(5, 0));
         do_hit(order[k]);
      end
      check("cleared", 128'(bus.draw_request), 128'(0));
   endtask

   // Idle clamp, RESPAWN_FRAMES frames, then ten load cycles. abort_k >= 0 resets mid-load.
   task automatic respawn(bit sat, int abort_k);
      int rx;
      int ry;
      int nvis;
      bus.clampIdle = 1'b1;
      step();
      bus.clampIdle = 1'b0;
      do_hit(0);
      for (int f = 0; f < 30; f++) begin
         bus.startOfFrame = 1'b1;
         step();
         bus.startOfFrame = 1'b0;
         if (f < 29) begin
            if (f == 28) check("delay_wave_hold", 128'(bus.wave_number), 128'(m_wave));
            step();
         end
      end
      m_wave = (m_wave + 1) % 16;
      for (int k = 0; k < 10; k++) m_vis[k] = 1'b0;
      check("load_wave", 128'(bus.wave_number), 128'(m_wave));
      check("load_draw_start", 128'(bus.draw_request), 128'(0));
      nvis = (m_wave + 4 > 10) ? 10 : m_wave + 4;
      for (int k = 0; k < 10; k++) begin
         if (k == abort_k) begin
            resetN = 1'b0;
            #1;
            model_reset();
            check_all("abort_reset");
            check("abort_hit", 128'(bus.hit_pulse), 128'(0));
            step();
            step();
            resetN = 1'b1;
            step();
            check_all("abort_release");
            return;
         end
         rx = sat ? 2000 : int'($urandom_range(2047, 0));
         ry = sat ? 5 : int'($urandom_range(2047, 0));
         bus.randX = 11'(rx);
         bus.randY = 11'(ry);
         step();
         m_x[k]   = clampi(rx, 16, 575);
         m_y[k]   = clampi(ry, 140, 415);
         m_vis[k] = (k < nvis);
         check("load_draw", 128'(bus.draw_request), 128'(vis_vec()));
      end
      m_active = 1'b1;
      check_all("loaded");
   endtask

   initial begin
      resetN              = 1'b0;
      bus.startOfFrame    = 1'b0;
      bus.collision       = 1'b0;
      bus.collision_index = '0;
      bus.clampIdle       = 1'b0;
      bus.randX           = '0;
      bus.randY           = '0;
      model_reset();
      #12;
      check_all("reset");
      check("reset_hit", 128'(bus.hit_pulse), 128'(0));
      check("reset_done", 128'(bus.wave_done), 128'(0));
      resetN = 1'b1;
      step();

      do_hit(3);
      check("idx3_pattern", 128'(bus.draw_request), 128'(10'b1110111111));
      do_hit(3);
      do_hit(12);
      check_all("after_ignored");

      clear_wave();

      // Clamp still launched: frames must not advance anything.
      for (int c = 0; c < 40; c++) begin
         bus.startOfFrame = c[0];
         step();
      end
      bus.startOfFrame = 1'b0;
      do_hit(4);
      check_all("wait_clamp_hold");

      respawn(1'b0, -1);
      check("wave1_visible", 128'(bus.draw_request), 128'(10'b1111100000));
      clear_wave();
      respawn(1'b1, -1);
      check("wave2_visible", 128'(bus.draw_request), 128'(10'b1111110000));
      for (int k = 0; k < 10; k++) begin
         check("sat_x", 128'(bus.topLeftX[k]), 128'(575));
         check("sat_y", 128'(bus.topLeftY[k]), 128'(140));
      end
      clear_wave();
      respawn(1'b0, 4);

      do_hit(5);
      do_hit(9);
      check_all("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vaccine_wave_controller.md
VACCINE_WAVE_CONTROLLER -- requirements
Module: vaccine_wave_controller

Interface
REQ-001 SHALL have parameter RESPAWN_FRAMES, default 30: frames waited between wave clear and reload.
REQ-002 SHALL have parameters X_MIN/X_MAX, default 16/575, and Y_MIN/Y_MAX, default 140/415: legal top-left bounds for respawned vaccines.
REQ-003 SHALL have port clk, input, 1: system clock.
REQ-004 SHALL have port resetN, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port startOfFrame, input, 1: one-clock pulse per video frame.
REQ-006 SHALL have port collision, input, 1: clamp-vaccine hit strobe, level sampled every clk.
REQ-007 SHALL have port collision_index, input, 4: slot hit, 0..9.
REQ-008 SHALL have port clampIdle, input, 1: clamp in circular (not launched) movement.
REQ-009 SHALL have ports randX and randY, input, 11 each: free-running random coordinates.
REQ-010 SHALL have ports topLeftX and topLeftY, output, [0:9][10:0]: per-slot positions.
REQ-011 SHALL have port draw_request, output, [0:9]: per-slot visible flags.
REQ-012 SHALL have port hit_pulse, output, 1: one-clock pulse per accepted hit.
REQ-013 SHALL have port wave_done, output, 1: one-clock pulse when the last visible slot clears.
REQ-014 SHALL have port wave_number, output, 4: current wave, wraps 15->0.

Function
REQ-015 SHALL implement FSM states ACTIVE, WAIT_CLAMP, DELAY, LOAD.
REQ-016 In ACTIVE, a hit SHALL be accepted when collision=1, collision_index<=9 and draw_request[index]=1.
REQ-017 An accepted hit SHALL clear that draw_request bit and pulse hit_pulse on the next clk.
REQ-018 Collisions with index>9, on an already-cleared slot, or in any state other than ACTIVE SHALL be ignored, with no pulse.
REQ-019 When an accepted hit clears the last set bit, wave_done SHALL pulse in the same cycle as hit_pulse, and the FSM SHALL go to WAIT_CLAMP.
REQ-020 In WAIT_CLAMP, clampIdle=1 SHALL move the FSM to DELAY and zero the frame counter.
REQ-021 In DELAY, each startOfFrame SHALL increment the frame counter.
REQ-022 On the startOfFrame that brings the frame counter to RESPAWN_FRAMES, the FSM SHALL go to LOAD and increment wave_number (mod 16).
REQ-023 Leaving DELAY to LOAD SHALL NOT depend on clampIdle.
REQ-024 LOAD SHALL take exactly 10 clks: slot k=0..9 is written in the k-th cycle.
REQ-025 In each LOAD cycle, topLeftX[k] SHALL be loaded with randX clamped to [X_MIN,X_MAX], and topLeftY[k] with randY clamped to [Y_MIN,Y_MAX], using unsigned compare.
REQ-026 In each LOAD cycle, draw_request[k] SHALL be set to 1 when k < min(4+wave_number,10), else 0.
REQ-027 After the slot-9 cycle, the FSM SHALL return to ACTIVE.
REQ-028 During LOAD, draw_request bits not yet written SHALL stay 0.
REQ-029 Positions of slots with draw_request=0 SHALL hold their last value.
REQ-030 Outputs SHALL be registered.
REQ-031 hit_pulse and wave_done SHALL never be high for more than one consecutive clk.

Reset
REQ-032 resetN=0 SHALL asynchronously force state ACTIVE, frame counter 0, load index 0, wave_number 0, hit_pulse 0, wave_done 0, and draw_request all ones.
REQ-033 resetN=0 SHALL asynchronously force topLeftX = 70,80,140,200,170,330,370,480,440,550 and topLeftY = 200,320,160,200,410,330,170,380,180,180 (slots 0..9).
REQ-034 Reset asserted mid-LOAD or mid-DELAY SHALL abort the operation with no residual partial writes after release.

Verification
REQ-035 Scenario: reset, then collision idx 3 for 1 clk -> draw_request=10'b1110111111, one hit_pulse; repeating idx 3 -> no pulse.
REQ-036 Scenario: collision idx 12 and collision while in DELAY -> no state, output or pulse change.
REQ-037 Scenario: hit all 10 slots -> wave_done coincides with 10th hit_pulse; clampIdle=0 holds WAIT_CLAMP indefinitely.
REQ-038 Scenario: clampIdle=1, then 30 startOfFrame pulses -> LOAD starts and wave_number=1; after 10 clks slots 0..4 are visible and 5..9 are cleared.
REQ-039 Scenario: randX=2000, randY=5 during LOAD -> every loaded slot reads X=575, Y=140.
REQ-040 Scenario: resetN low at LOAD cycle 4 -> reset layout and 10'h3FF restored immediately and the FSM is in ACTIVE after release.
